clock_set_controller: RTL

//   Front end of the digital clock: debounces the MODE and INC buttons, runs the
//   set-mode state machine, and produces the 1 Hz base tick. Drives the tick/set/

---
 rtl/clock_pkg.sv | 23 ++
 rtl/button_debounce.sv | 61 ++++++
 rtl/clock_set_controller.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the digital clock front end.
package clock_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SET_HR  = 2'd1,
      SET_MIN = 2'd2,
      SET_SEC = 2'd3
   } set_state_t;

   localparam int CNT_W = 32;

   // MODE presses cycle RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN.
   function automatic set_state_t nextMode(input set_state_t s);
      case (s)
         RUN:     return SET_HR;
         SET_HR:  return SET_MIN;
         SET_MIN: return SET_SEC;
         default: return RUN;
      endcase
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Button conditioning: 2-FF synchroniser, debounce counter and a one-cycle
// press pulse on the rising edge of the debounced level.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 500_000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic press
);
   import clock_pkg::*;

   logic sync1_q, sync2_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic level_q, level_d;
   logic press_q, press_d;

   // Bring the asynchronous button into the clk domain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
      end
   end

   // Count consecutive samples that disagree with the debounced level; any agreeing sample restarts the count.
   always_comb begin
      count_d = '0;
      level_d = level_q;
      press_d = 1'b0;
      if (sync2_q != level_q) begin
         if (count_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = ~level_q;
            press_d = ~level_q;
         end else begin
            count_d = count_q + 1'b1;
         end
      end
   end

   // Debounce state and press pulse registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         count_q <= count_d;
         level_q <= level_d;
         press_q <= press_d;
      end
   end

   assign level = level_q;
   assign press = press_q;

endmodule

// File: rtl/clock_set_controller.sv
// Digital clock front end: debounced MODE/INC buttons, set-mode FSM, 1 Hz
// prescaler and the shared increment pulse. Define AUTO_REPEAT_EN to make a
// held INC button auto-repeat in the set states.
module clock_set_controller #(
   parameter int TICK_DIV        = 50_000_000,
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int REPEAT_DELAY    = 25_000_000,
   parameter int REPEAT_RATE     = 5_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic       sec_tick,
   output logic       set_hr,
   output logic       set_min,
   output logic       set_sec,
   output logic       increment,
   output logic [1:0] mode_state
);
   import clock_pkg::*;

   if (TICK_DIV < 2 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : gBadParams
      $error("clock_set_controller: illegal parameter value");
   end

   logic modeLevel, modePress, incLevel, incPress;
   logic unusedModeLevel;
   set_state_t state_q, state_d;
   logic inSet, repeatFire;
   logic [CNT_W-1:0] presCount_q, presCount_d;
   logic secTick_q, secTick_d;
   logic increment_q, increment_d;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uModeButton (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_mode),
      .level (modeLevel),
      .press (modePress)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uIncButton (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_inc),
      .level (incLevel),
      .press (incPress)
   );

   assign unusedModeLevel = modeLevel;

   // Set-mode state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= RUN;
      else       state_q <= state_d;
   end

   // Advance the mode on every MODE press.
   always_comb begin
      state_d = state_q;
      if (modePress) state_d = nextMode(state_q);
   end

   // Decode the registered state into the counter-chain set enables.
   always_comb begin
      inSet      = (state_q != RUN);
      set_hr     = (state_q == SET_HR);
      set_min    = (state_q == SET_MIN);
      set_sec    = (state_q == SET_SEC);
      mode_state = state_q;
   end

   // Prescaler counts only while running; a tick is suppressed if we are leaving RUN in that same cycle.
   always_comb begin
      presCount_d = '0;
      secTick_d   = 1'b0;
      if (state_q == RUN) begin
         if (presCount_q == CNT_W'(TICK_DIV - 1)) begin
            secTick_d = (state_d == RUN);
         end else begin
            presCount_d = presCount_q + 1'b1;
         end
      end
   end

`ifdef AUTO_REPEAT_EN
   logic [CNT_W-1:0] repCount_q, repCount_d;
   logic repeating_q, repeating_d;
   logic holdOk;

   // Repeat timer: starts at the press, waits REPEAT_DELAY, then fires every REPEAT_RATE while INC stays held in a set state.
   always_comb begin
      holdOk      = incLevel && inSet && !modePress;
      repCount_d  = '0;
      repeating_d = 1'b0;
      repeatFire  = 1'b0;
      if (holdOk) begin
         if (incPress) begin
            repCount_d = CNT_W'(1);
         end else if (repCount_q != '0) begin
            if (repCount_q == (repeating_q ? CNT_W'(REPEAT_RATE) : CNT_W'(REPEAT_DELAY))) begin
               repeatFire  = 1'b1;
               repCount_d  = CNT_W'(1);
               repeating_d = 1'b1;
            end else begin
               repCount_d  = repCount_q + 1'b1;
               repeating_d = repeating_q;
            end
         end
      end
   end

   // Repeat timer registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         repCount_q  <= '0;
         repeating_q <= 1'b0;
      end else begin
         repCount_q  <= repCount_d;
         repeating_q <= repeating_d;
      end
   end
`else
   logic unusedIncLevel;
   assign unusedIncLevel = incLevel;
   assign repeatFire     = 1'b0;
`endif

   // An INC press (or repeat) increments only in a set state, and a simultaneous MODE press wins.
   always_comb begin
      increment_d = inSet && !modePress && (incPress || repeatFire);
   end

   // Registered outputs and prescaler count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presCount_q <= '0;
         secTick_q   <= 1'b0;
         increment_q <= 1'b0;
      end else begin
         presCount_q <= presCount_d;
         secTick_q   <= secTick_d;
         increment_q <= increment_d;
      end
   end

   assign sec_tick  = secTick_q;
   assign increment = increment_q;

endmodule
